// File: rtl/unit_a_serial.sv
// Chunk-serial add/sub/negate/increment unit with registered N/Z/C/O flags and start/done handshake.
// Optional build macro UNIT_A_SAT_EN clamps the result on signed overflow.
module unit_a_serial #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       f,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             O,
  output logic             N,
  output logic             Z
);

  localparam int NCH   = WIDTH / CHUNK;
  localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NCH - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                    state, state_nxt;
  logic                      accept, finish;
  logic [WIDTH-1:0]          a_fa, b_fa, work;
  logic                      carry;
  logic [IDX_W-1:0]          idx;
  logic [CHUNK:0]            sum_ch;
  logic [WIDTH-1:0]          sum_full;
  logic signed [WIDTH-1:0]   s_fin;
  logic                      ovf;
  logic                      unused_f;

  assign unused_f = ^f[3:2];

`ifdef UNIT_A_SAT_EN
  function automatic logic signed [WIDTH-1:0] saturate(
    input logic signed [WIDTH-1:0] raw,
    input logic                    of,
    input logic                    a_msb
  );
    logic signed [WIDTH-1:0] max_pos, min_neg;
    max_pos = {1'b0, {(WIDTH-1){1'b1}}};
    min_neg = {1'b1, {(WIDTH-1){1'b0}}};
    if (!of) return raw;
    return a_msb ? min_neg : max_pos;
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    finish    = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (idx == LAST) begin
          finish    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Chunk adder: the current chunk is merged into the working sum combinationally
  always_comb begin
    sum_ch   = {1'b0, a_fa[int'(idx)*CHUNK +: CHUNK]}
             + {1'b0, b_fa[int'(idx)*CHUNK +: CHUNK]}
             + {{CHUNK{1'b0}}, carry};
    sum_full = work;
    sum_full[int'(idx)*CHUNK +: CHUNK] = sum_ch[CHUNK-1:0];
    ovf      = (a_fa[WIDTH-1] == b_fa[WIDTH-1]) & (sum_full[WIDTH-1] != a_fa[WIDTH-1]);
`ifdef UNIT_A_SAT_EN
    s_fin    = saturate(sum_full, ovf, a_fa[WIDTH-1]);
`else
    s_fin    = sum_full;
`endif
  end

  // Operand capture and working sum carry no reset; they are always written before use
  always_ff @(posedge clk) begin
    if (accept) begin
      a_fa <= a & ~{WIDTH{f[1]}};
      b_fa <= b ^ {WIDTH{f[1] ^ f[0]}};
    end
    if (state == RUN) work <= sum_full;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      carry <= 1'b0;
      idx   <= '0;
      done  <= 1'b0;
      s     <= '0;
      c_out <= 1'b0;
      O     <= 1'b0;
      N     <= 1'b0;
      Z     <= 1'b0;
    end else begin
      done <= finish;
      if (accept) begin
        carry <= f[1] | f[0];
        idx   <= '0;
      end else if (state == RUN) begin
        carry <= sum_ch[CHUNK];
        idx   <= finish ? '0 : idx + 1'b1;
        if (finish) begin
          s     <= s_fin;
          c_out <= sum_ch[CHUNK];
          O     <= ovf;
          N     <= s_fin[WIDTH-1];
          Z     <= (s_fin == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_unit_a_serial.sv
// Scoreboard bench for unit_a_serial: a CHUNK=8 instance and a CHUNK=32 instance,
// directed cases followed by randomized traffic against an arithmetic reference model.
module tb_unit_a_serial;

  typedef struct packed {
    logic [31:0] s;
    logic        c;
    logic        o;
    logic        n;
    logic        z;
    logic [31:0] cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start0 = 1'b0, start1 = 1'b0;
  logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic [3:0]  f0 = '0, f1 = '0;
  logic        busy0, done0, c0, o0, n0, z0;
  logic        busy1, done1, c1, o1, n1, z1;
  logic [31:0] s0, s1;

  int   cyc = 0;
  logic rst_prev = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t held[2];
  int   bstart[2] = '{0, 0};
  int   bend[2] = '{0, 0};
  int   next_free[2] = '{0, 0};
  int   nch[2] = '{4, 1};

  unit_a_serial #(.WIDTH(32), .CHUNK(8)) u0 (
    .clk(clk), .rst(rst), .start(start0), .a(a0), .b(b0), .f(f0),
    .busy(busy0), .done(done0), .s(s0), .c_out(c0), .O(o0), .N(n0), .Z(z0)
  );

  unit_a_serial #(.WIDTH(32), .CHUNK(32)) u1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .f(f1),
    .busy(busy1), .done(done1), .s(s1), .c_out(c1), .O(o1), .N(n1), .Z(z1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_prev <= rst;
  end

  // Reference: true signed/unsigned results in 64-bit arithmetic
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] f);
    exp_t   e;
    longint sa, sb, ua, ub, r;
    logic   c;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    case (f[1:0])
      2'b00:   begin r = sa + sb; c = (ua + ub) >= 64'h1_0000_0000; end
      2'b01:   begin r = sa - sb; c = (ua >= ub); end
      2'b10:   begin r = -sb;     c = (ub == 0); end
      default: begin r = sb + 1;  c = (ub == 64'hFFFF_FFFF); end
    endcase
    e   = '0;
    e.c = c;
    e.o = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    e.s = r[31:0];
`ifdef UNIT_A_SAT_EN
    if (e.o) e.s = (r > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
`endif
    e.n = e.s[31];
    e.z = (e.s == 32'h0);
    return e;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic check_unit(input int u, input logic dn, input logic bz, input logic [31:0] sv,
                            input logic cv, input logic ov, input logic nv, input logic zv);
    exp_t e;
    logic hit;
    logic bexp;
    e   = '0;
    hit = 1'b0;
    if (rst_prev) held[u] = '0;
    if (u == 0) begin
      if (q0.size() > 0 && int'(q0[0].cyc) == cyc) begin e = q0.pop_front(); hit = 1'b1; end
    end else begin
      if (q1.size() > 0 && int'(q1[0].cyc) == cyc) begin e = q1.pop_front(); hit = 1'b1; end
    end
    if (hit) held[u] = e;
    bexp = (cyc >= bstart[u]) && (cyc < bend[u]);
    chk($sformatf("u%0d_done", u), {31'b0, dn}, {31'b0, hit});
    chk($sformatf("u%0d_busy", u), {31'b0, bz}, {31'b0, bexp});
    chk($sformatf("u%0d_s", u), sv, held[u].s);
    chk($sformatf("u%0d_C", u), {31'b0, cv}, {31'b0, held[u].c});
    chk($sformatf("u%0d_O", u), {31'b0, ov}, {31'b0, held[u].o});
    chk($sformatf("u%0d_N", u), {31'b0, nv}, {31'b0, held[u].n});
    chk($sformatf("u%0d_Z", u), {31'b0, zv}, {31'b0, held[u].z});
  endtask

  always @(negedge clk) begin
    if (cyc >= 1) begin
      check_unit(0, done0, busy0, s0, c0, o0, n0, z0);
      check_unit(1, done1, busy1, s1, c1, o1, n1, z1);
    end
  end

  // One clock of stimulus; the expectation for an accepted start is queued here
  task automatic step(input int u, input logic r, input logic st,
                      input logic [31:0] av, input logic [31:0] bv, input logic [3:0] fv);
    int   e;
    exp_t x;
    e   = cyc + 1;
    rst = r;
    if (u == 0) begin start0 = st; a0 = av; b0 = bv; f0 = fv; end
    else        begin start1 = st; a1 = av; b1 = bv; f1 = fv; end
    if (r) begin
      for (int k = 0; k < 2; k++) begin
        if (bend[k] > e) bend[k] = e;
        next_free[k] = e + 1;
      end
      while (q0.size() > 0 && int'(q0[$].cyc) >= e) void'(q0.pop_back());
      while (q1.size() > 0 && int'(q1[$].cyc) >= e) void'(q1.pop_back());
    end else if (st && e >= next_free[u]) begin
      x     = model(av, bv, fv);
      x.cyc = 32'(e + nch[u]);
      if (u == 0) q0.push_back(x);
      else        q1.push_back(x);
      bstart[u]    = e;
      bend[u]      = e + nch[u];
      next_free[u] = e + nch[u] + 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int u);
    step(u, 1'b0, 1'b0, pick(), pick(), 4'($urandom_range(0, 15)));
  endtask

  task automatic wait_free(input int u);
    while (cyc + 1 < next_free[u]) idle(u);
  endtask

  initial begin
    // reset held for three edges with start asserted: start must not be taken
    for (int i = 0; i < 3; i++) step(0, 1'b1, 1'b1, 32'h1, 32'h1, 4'h0);

    step(0, 1'b0, 1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 4'h0);
    wait_free(0);
    step(0, 1'b0, 1'b1, 32'd5, 32'd5, 4'h1);
    wait_free(0);
    step(0, 1'b0, 1'b1, 32'h1234, 32'h1, 4'h2);
    wait_free(0);
    step(0, 1'b0, 1'b1, 32'h0, 32'hFFFF_FFFF, 4'h3);
    wait_free(0);

    // start during RUN ignored; start in the done cycle accepted
    step(0, 1'b0, 1'b1, 32'd1, 32'd2, 4'h0);
    step(0, 1'b0, 1'b1, 32'd9, 32'd9, 4'h0);
    wait_free(0);
    step(0, 1'b0, 1'b1, 32'd6, 32'd7, 4'h1);
    wait_free(0);

    // reset in the second RUN cycle, then a normal add
    step(0, 1'b0, 1'b1, 32'd10, 32'd20, 4'h0);
    idle(0);
    step(0, 1'b1, 1'b0, 32'd0, 32'd0, 4'h0);
    step(0, 1'b0, 1'b1, 32'd2, 32'd3, 4'h0);
    wait_free(0);

    for (int i = 0; i < 300; i++) begin
      int r;
      r = $urandom_range(0, 99);
      step(0, r < 2, r >= 45, pick(), pick(), 4'($urandom_range(0, 15)));
    end
    for (int i = 0; i < 6; i++) idle(0);
    chk("u0_drain", q0.size(), 32'd0);

    step(1, 1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000, 4'h0);
    wait_free(1);
    for (int i = 0; i < 60; i++) begin
      int r;
      r = $urandom_range(0, 99);
      step(1, r < 3, r >= 40, pick(), pick(), 4'($urandom_range(0, 15)));
    end
    for (int i = 0; i < 4; i++) idle(1);
    chk("u1_drain", q1.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
